decoder_3_8: RTL and testbench



---
 rtl/decoder_3_8.sv | 46 ++++
 tb/tb_decoder_3_8.sv | 135 +++++++++++++
 2 files changed

// File: rtl/decoder_3_8.sv
// Registered 3-to-8 decoder: s selects one of eight output bits, polarity set by ACTIVE_LOW.
// valid marks cycles where d carries a decode of an enabled select code.
module decoder_3_8 #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] s,
    output logic [7:0] d,
    output logic       valid
);

    localparam logic [7:0] INACT = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [7:0] one_hot;
    logic [7:0] d_d;
    logic [7:0] d_q;
    logic       valid_d;
    logic       valid_q;

    always_comb begin
        one_hot = 8'h01 << s;
        d_d     = INACT;
        valid_d = 1'b0;
        if (en) begin
            // Inverting the one-hot word gives the one-cold form with a single 0 at bit s.
            d_d     = ACTIVE_LOW ? ~one_hot : one_hot;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q     <= INACT;
            valid_q <= 1'b0;
        end else begin
            d_q     <= d_d;
            valid_q <= valid_d;
        end
    end

    assign d     = d_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_decoder_3_8.sv
// Self-checking bench for decoder_3_8: directed sequences plus random stimulus on both polarities,
// each cycle compared against an arithmetic reference model through an expected queue.
module tb_decoder_3_8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] s;
    logic [7:0] d_hi;
    logic       valid_hi;
    logic [7:0] d_lo;
    logic       valid_lo;

    int n_cmp;
    int n_err;

    // Packed expectation: {valid_lo, d_lo, valid_hi, d_hi}
    logic [17:0] exp_q[$];

    decoder_3_8 #(.ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .s     (s),
        .d     (d_hi),
        .valid (valid_hi)
    );

    decoder_3_8 #(.ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .s     (s),
        .d     (d_lo),
        .valid (valid_lo)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: arithmetic weight of the selected bit, inverted as 255 - weight for one-cold.
    function automatic logic [8:0] model(input bit active_low, input bit r, input bit e, input int sel);
        int w;
        int inact;
        inact = active_low ? 255 : 0;
        if (r || !e) return {1'b0, 8'(inact)};
        w = 2 ** sel;
        return {1'b1, active_low ? 8'(255 - w) : 8'(w)};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Driver: apply one cycle of inputs, queue the model result, check after the edge.
    task automatic step(input bit r, input bit e, input logic [2:0] sel);
        logic [8:0]  m_hi;
        logic [8:0]  m_lo;
        logic [17:0] got;
        rst = r;
        en  = e;
        s   = sel;
        m_hi = model(1'b0, r, e, int'(sel));
        m_lo = model(1'b1, r, e, int'(sel));
        exp_q.push_back({m_lo, m_hi});
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check("d_hi",     d_hi,            got[7:0]);
        check("valid_hi", {7'd0, valid_hi}, {7'd0, got[8]});
        check("d_lo",     d_lo,            got[16:9]);
        check("valid_lo", {7'd0, valid_lo}, {7'd0, got[17]});
        check("ones_hi",  8'($countones(d_hi)),  {7'd0, valid_hi});
        check("zeros_lo", 8'($countones(~d_lo)), {7'd0, valid_lo});
    endtask

    // Scoreboard-independent spot checks against literal values from the mapping table.
    task automatic expect_lit(input string tag, input logic [7:0] hi, input logic [7:0] lo, input bit v);
        check({tag, "_hi"}, d_hi, hi);
        check({tag, "_lo"}, d_lo, lo);
        check({tag, "_v"},  {7'd0, valid_hi}, {7'd0, v});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        en    = 1'b1;
        s     = 3'd5;
        @(posedge clk);
        #1;

        // Reset held with en=1, s=5, then release
        step(1'b1, 1'b1, 3'd5);
        expect_lit("rst0", 8'h00, 8'hFF, 1'b0);
        step(1'b1, 1'b1, 3'd5);
        expect_lit("rst1", 8'h00, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 3'd5);
        expect_lit("rel", 8'h20, 8'hDF, 1'b1);

        // Free-running counter through two wraps
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 3'(i));
        expect_lit("wrap", 8'h01, 8'hFE, 1'b1);

        // Enable toggle with s=2
        step(1'b0, 1'b1, 3'd2);
        expect_lit("en1a", 8'h04, 8'hFB, 1'b1);
        step(1'b0, 1'b0, 3'd2);
        expect_lit("en0", 8'h00, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 3'd2);
        expect_lit("en1b", 8'h04, 8'hFB, 1'b1);

        // Single-cycle reset mid-decode of s=7
        step(1'b0, 1'b1, 3'd7);
        expect_lit("mid_a", 8'h80, 8'h7F, 1'b1);
        step(1'b1, 1'b1, 3'd7);
        expect_lit("mid_r", 8'h00, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 3'd7);
        expect_lit("mid_b", 8'h80, 8'h7F, 1'b1);

        // Random stimulus
        for (int i = 0; i < 1200; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
